// File: rtl/inst_fetch_bridge.sv
// Word-fetch responder: four little-endian byte reads from a synchronous byte memory.
// Define FETCH_BRIDGE_LASTWORD_EN to add a one-entry last-word cache.
module inst_fetch_bridge #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    output logic              rom_rdy,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_re,
    input  logic [7:0]        mem_din
);

    localparam int WW = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state;
    logic [WW-1:0]     w_q;
    logic [1:0]        iss_k;
    logic [2:0]        cap_n;
    logic [RD_LAT-1:0] cap_sr;
    logic [23:0]       shadow;

    logic [WW-1:0] req_w;
    logic          abort;
    logic          cap_fire;
    logic [1:0]    nxt_k;
    logic [RD_LAT:0] sr_n;
    logic          unused_bits;

    assign req_w       = rom_addr[ADDR_W-1:2];
    assign abort       = !rom_ce || (req_w != w_q);
    assign cap_fire    = cap_sr[RD_LAT-1];
    assign nxt_k       = iss_k + 2'd1;
    assign sr_n        = {cap_sr, state == ISSUE};
    assign unused_bits = ^{rom_addr[31:ADDR_W], rom_addr[1:0]};

`ifdef FETCH_BRIDGE_LASTWORD_EN
    logic          tag_v;
    logic [WW-1:0] tag_w;
    logic [31:0]   tag_d;
    logic          hit;
    assign hit = tag_v && (tag_w == req_w);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            w_q      <= '0;
            iss_k    <= '0;
            cap_n    <= '0;
            cap_sr   <= '0;
            shadow   <= '0;
            rom_data <= '0;
            rom_rdy  <= 1'b0;
            mem_a    <= '0;
            mem_re   <= 1'b0;
`ifdef FETCH_BRIDGE_LASTWORD_EN
            tag_v    <= 1'b0;
            tag_w    <= '0;
            tag_d    <= '0;
`endif
        end else begin
            rom_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    // a hit pulse is answered in IDLE; skip one sample so it stays one cycle
                    if (rom_ce && !rom_rdy) begin
`ifdef FETCH_BRIDGE_LASTWORD_EN
                        if (hit) begin
                            rom_data <= tag_d;
                            rom_rdy  <= 1'b1;
                        end else begin
                            w_q    <= req_w;
                            mem_a  <= {req_w, 2'b00};
                            mem_re <= 1'b1;
                            iss_k  <= 2'd0;
                            cap_n  <= 3'd0;
                            cap_sr <= '0;
                            state  <= ISSUE;
                        end
`else
                        w_q    <= req_w;
                        mem_a  <= {req_w, 2'b00};
                        mem_re <= 1'b1;
                        iss_k  <= 2'd0;
                        cap_n  <= 3'd0;
                        cap_sr <= '0;
                        state  <= ISSUE;
`endif
                    end
                end
                ISSUE, DRAIN: begin
                    if (abort) begin
                        // in-flight bytes are dropped with the flushed shift register
                        state  <= IDLE;
                        mem_re <= 1'b0;
                        cap_sr <= '0;
                        cap_n  <= 3'd0;
                    end else begin
                        cap_sr <= sr_n[RD_LAT-1:0];
                        if (cap_fire) begin
                            cap_n <= cap_n + 3'd1;
                            if (cap_n == 3'd3) begin
                                rom_data <= {mem_din, shadow};
                                rom_rdy  <= 1'b1;
`ifdef FETCH_BRIDGE_LASTWORD_EN
                                tag_v <= 1'b1;
                                tag_w <= w_q;
                                tag_d <= {mem_din, shadow};
`endif
                            end else begin
                                shadow[{cap_n[1:0], 3'b000} +: 8] <= mem_din;
                            end
                        end
                        if (state == ISSUE) begin
                            if (iss_k == 2'd3) begin
                                mem_re <= 1'b0;
                                state  <= DRAIN;
                            end else begin
                                mem_a <= {w_q, nxt_k};
                                iss_k <= nxt_k;
                            end
                        end else if (rom_rdy) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
